// File: rtl/uart_tx_fifo_reader.sv
// UART transmitter that drains a show-ahead TX FIFO and sends each byte as
// an 8N1 frame. A private 16x oversample divider sets the bit timing; it is
// held at zero while idle so every frame starts with identical phase.
module uart_tx_fifo_reader #(
    parameter int unsigned CLK_FREQ = 100_000_000,
    parameter int unsigned BAUD     = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_rdata,
    output logic       fifo_pop,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int unsigned DivRaw = CLK_FREQ / (BAUD * 16);
    localparam int unsigned Div    = (DivRaw < 1) ? 1 : DivRaw;
    localparam int unsigned DivW   = (Div > 1) ? $clog2(Div) : 1;
    localparam logic [DivW-1:0] DivMax = DivW'(Div - 1);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } state_e;

    state_e          state_q, state_d;
    logic [DivW-1:0] div_q, div_d;
    logic [3:0]      tick_q, tick_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_q, tx_d;

    logic tick;
    logic bit_end;

    // State, counters, shift register and the registered line driver.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            div_q   <= '0;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    // Next-state logic; tx_d is the line level for the following cycle.
    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        tick_d   = tick_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
        fifo_pop = 1'b0;
        tx_done  = 1'b0;

        tick    = (div_q == DivMax);
        bit_end = tick && (tick_q == 4'hF);

        if (state_q != StIdle) begin
            div_d = tick ? '0 : div_q + 1'b1;
            if (tick) begin
                tick_d = tick_q + 4'd1;
            end
        end

        case (state_q)
            StIdle: begin
                div_d  = '0;
                tick_d = '0;
                bit_d  = '0;
                tx_d   = 1'b1;
                // Gated by rst so no pop can be issued while reset is held.
                if (en && !fifo_empty && rst) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_rdata;
                    tx_d     = 1'b0;
                    state_d  = StStart;
                end
            end
            StStart: begin
                if (bit_end) begin
                    tx_d    = shift_q[0];
                    state_d = StData;
                end
            end
            StData: begin
                if (bit_end) begin
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = StStop;
                    end else begin
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                        bit_d   = bit_q + 3'd1;
                    end
                end
            end
            StStop: begin
                if (bit_end) begin
                    tx_done = 1'b1;
                    tx_d    = 1'b1;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                tx_d    = 1'b1;
            end
        endcase
    end

    assign tx      = tx_q;
    assign tx_busy = (state_q != StIdle);

endmodule
